// File: rtl/decrypt_stream.sv
// ============================================================================
// Module      : decrypt_stream
// Description : Byte-serial stream decryptor. Each cipher byte has the next
//               byte of a cyclically repeated secret subtracted from it
//               (mod 256). Valid/ready handshakes on the input and output
//               sides; one message of p_message_length bytes per start pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decrypt_stream #(
  parameter int p_message_length = 15,
  parameter int p_secret_length  = 6
) (
  input  logic                         i_w_clk,
  input  logic                         i_w_rst_n,
  input  logic                         i_w_start,
  input  logic [p_secret_length*8-1:0] i_w_secret,
  input  logic                         i_w_cip_valid,
  output logic                         o_w_cip_ready,
  input  logic [7:0]                   i_w_cipher,
  output logic                         o_r_txt_valid,
  input  logic                         i_w_txt_ready,
  output logic [7:0]                   o_r_text,
  output logic                         o_r_done
);

  localparam int IW = (p_secret_length > 1) ? $clog2(p_secret_length) : 1;
  localparam int CW = $clog2(p_message_length + 1);

  localparam logic [IW-1:0] IDX_LAST = IW'(p_secret_length - 1);
  localparam logic [CW-1:0] MSG_LEN  = CW'(p_message_length);
  localparam logic [CW-1:0] MSG_LAST = CW'(p_message_length - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                       state;
  state_t                       state_nxt;
  logic [p_secret_length*8-1:0] secret;
  logic [IW-1:0]                idx;
  logic [CW-1:0]                in_count;
  logic [CW-1:0]                out_count;
  logic [7:0]                   key;
  logic                         xfer;
  logic                         accept;
  logic                         last_accept;

  assign accept      = o_r_txt_valid && i_w_txt_ready;
  assign last_accept = accept && (out_count == MSG_LAST);

  // Input-side handshake; a start pulse wins over any coincident transfer
  always_comb begin
    o_w_cip_ready = (state == RUN) && (in_count < MSG_LEN) &&
                    (!o_r_txt_valid || i_w_txt_ready);
    xfer          = i_w_cip_valid && o_w_cip_ready && !i_w_start;
  end

  // Select the key byte for the current index; byte 0 of the secret is the MSB
  always_comb begin
    key = 8'h00;
    for (int i = 0; i < p_secret_length; i++) begin
      if (idx == IW'(i)) begin
        key = secret[(p_secret_length-1-i)*8 +: 8];
      end
    end
  end

  // State register
  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: start always (re)enters RUN, last accepted byte ends it
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_w_start) state_nxt = RUN;
      RUN: begin
        if (i_w_start)        state_nxt = RUN;
        else if (last_accept) state_nxt = DONE;
      end
      DONE:    if (i_w_start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: secret latch, key index, byte counters and output register
  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      secret        <= '0;
      idx           <= '0;
      in_count      <= '0;
      out_count     <= '0;
      o_r_text      <= 8'h00;
      o_r_txt_valid <= 1'b0;
      o_r_done      <= 1'b0;
    end else if (i_w_start) begin
      secret        <= i_w_secret;
      idx           <= '0;
      in_count      <= '0;
      out_count     <= '0;
      o_r_txt_valid <= 1'b0;
      o_r_done      <= 1'b0;
    end else begin
      // A new byte refills the output register in the same cycle the old one
      // leaves, so back-to-back transfers have no bubble
      if (xfer) begin
        o_r_text      <= i_w_cipher - key;
        o_r_txt_valid <= 1'b1;
        idx           <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        in_count      <= in_count + 1'b1;
      end else if (accept) begin
        o_r_txt_valid <= 1'b0;
      end
      if (accept) begin
        out_count <= out_count + 1'b1;
      end
      if (last_accept) begin
        o_r_done <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_decrypt_stream.sv
// ============================================================================
// Module      : tb_decrypt_stream
// Description : Self-checking bench for decrypt_stream: known-answer table,
//               backpressure / message-end / reset sequences and randomized
//               encrypt-then-decrypt round trips against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decrypt_stream;

  localparam int ML = 15;
  localparam int SL = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [SL*8-1:0] secret;
  logic          cip_valid;
  logic          cip_ready;
  logic [7:0]    cipher;
  logic          txt_valid;
  logic          txt_ready;
  logic [7:0]    text;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: latched secret, bytes taken in / delivered, and a queue
  // of plaintext bytes produced but not yet accepted by the sink
  logic [SL*8-1:0] m_secret;
  int              m_in;
  int              m_out;
  bit              m_run;
  logic [7:0]      m_q[$];

  // Optional independent plaintext for round-trip checking
  bit              rt_on;
  logic [7:0]      rt_plain[ML];

  decrypt_stream #(
    .p_message_length(ML),
    .p_secret_length (SL)
  ) dut (
    .i_w_clk      (clk),
    .i_w_rst_n    (rst_n),
    .i_w_start    (start),
    .i_w_secret   (secret),
    .i_w_cip_valid(cip_valid),
    .o_w_cip_ready(cip_ready),
    .i_w_cipher   (cipher),
    .o_r_txt_valid(txt_valid),
    .i_w_txt_ready(txt_ready),
    .o_r_text     (text),
    .o_r_done     (done)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  function automatic logic [7:0] key_of(input logic [SL*8-1:0] s, input int k);
    return s[(SL-1-(k % SL))*8 +: 8];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle, entered and left at a falling edge. Inputs are applied,
  // outputs checked against the model, then the model advances as the DUT will
  // at the coming rising edge.
  task automatic cycle(input logic st, input logic cv, input logic [7:0] c, input logic tr);
    bit exp_rdy;
    start     = st;
    cip_valid = cv;
    cipher    = c;
    txt_ready = tr;
    #1;
    exp_rdy = m_run && (m_in < ML) && (m_q.size() == 0 || tr);
    check("txt_valid", txt_valid, m_q.size() != 0);
    check("done", done, m_run && (m_out >= ML));
    if (!st) check("cip_ready", cip_ready, exp_rdy);
    if (st) begin
      m_secret = secret;
      m_in     = 0;
      m_out    = 0;
      m_run    = 1;
      m_q.delete();
    end else begin
      if (m_q.size() != 0 && tr) begin
        check("text", text, m_q.pop_front());
        if (rt_on) check("roundtrip", text, rt_plain[m_out]);
        m_out++;
      end
      if (cv && exp_rdy) begin
        m_q.push_back(c - key_of(m_secret, m_in));
        m_in++;
      end
    end
    @(negedge clk);
  endtask

  typedef struct {
    bit         st;
    logic [7:0] c;
    logic [7:0] t;
  } vec_t;

  vec_t       vt[9];
  logic [7:0] held;

  initial begin
    // Known-answer vectors; st=1 rows begin a fresh message first
    vt[0] = '{1'b1, 8'h98, 8'h54};
    vt[1] = '{1'b0, 8'h90, 8'h4F};
    vt[2] = '{1'b0, 8'h9E, 8'h50};
    vt[3] = '{1'b0, 8'h9C, 8'h53};
    vt[4] = '{1'b0, 8'h91, 8'h45};
    vt[5] = '{1'b0, 8'h84, 8'h43};
    vt[6] = '{1'b0, 8'h98, 8'h54};
    vt[7] = '{1'b1, 8'h04, 8'hC0};
    vt[8] = '{1'b1, 8'h44, 8'h00};

    rst_n = 1'b0; start = 1'b0; secret = '0; cip_valid = 1'b0;
    cipher = 8'h00; txt_ready = 1'b0;
    m_secret = '0; m_in = 0; m_out = 0; m_run = 0; rt_on = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", txt_valid, 0);
    check("rst_text", text, 0);
    check("rst_done", done, 0);
    check("rst_ready", cip_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // IDLE must not accept data
    cycle(0, 1, 8'h12, 1);
    cycle(0, 1, 8'h34, 1);

    // Known answers with secret "DANILA", sink always ready
    secret = "DANILA";
    for (int i = 0; i < 9; i++) begin
      if (vt[i].st) cycle(1, 0, 8'h00, 1);
      cycle(0, 1, vt[i].c, 1);
      check("vec_valid", txt_valid, 1);
      check("vec_text", text, vt[i].t);
    end
    cycle(0, 0, 8'h00, 1);

    // Backpressure mid-stream, then run the message to completion
    cycle(1, 0, 8'h00, 1);
    for (int i = 0; i < 4; i++) cycle(0, 1, 8'($urandom), 1);
    held = text;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 8'hAA, 0);
      check("bp_text", text, held);
    end
    for (int n = 0; n < 100 && m_out < ML; n++) cycle(0, 1, 8'($urandom), 1);
    check("msg_complete", m_out, ML);
    cycle(0, 1, 8'h55, 1);
    cycle(0, 1, 8'h66, 1);
    check("done_hold", done, 1);

    // Second start restarts the key at 'D'
    cycle(1, 0, 8'h00, 1);
    cycle(0, 1, 8'h44, 1);
    check("restart_text", text, 8'h00);
    cycle(0, 0, 8'h00, 1);

    // Asynchronous reset after five bytes, then a clean restart
    cycle(1, 0, 8'h00, 1);
    for (int i = 0; i < 5; i++) cycle(0, 1, 8'h90 + 8'(i), 1);
    start = 1'b0; cip_valid = 1'b0; txt_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", txt_valid, 0);
    check("arst_text", text, 0);
    check("arst_done", done, 0);
    check("arst_ready", cip_ready, 0);
    m_run = 0; m_in = 0; m_out = 0; m_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cycle(1, 0, 8'h00, 1);
    cycle(0, 1, 8'h44, 1);
    check("post_rst_text", text, 8'h00);
    cycle(0, 0, 8'h00, 1);

    // Random round trips: encrypt random text, stream it with random
    // valid/ready, secret input scrambled after each start
    rt_on = 1;
    for (int msg = 0; msg < 70; msg++) begin
      logic [7:0] enc[ML];
      secret = {$urandom, $urandom};
      for (int k = 0; k < ML; k++) rt_plain[k] = 8'($urandom);
      cycle(1, 0, 8'h00, 1);
      for (int k = 0; k < ML; k++) enc[k] = rt_plain[k] + key_of(m_secret, k);
      for (int n = 0; n < 400 && m_out < ML; n++) begin
        secret = {$urandom, $urandom};
        cycle(0, ($urandom % 4) != 0, (m_in < ML) ? enc[m_in] : 8'h00,
              ($urandom % 4) != 0);
      end
      check("rt_complete", m_out, ML);
    end
    rt_on = 0;
    cycle(0, 1, 8'h00, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
